// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Watches a multiplexed 7-segment display bus and recovers the four
//   hex digits it shows. A {seg_in, dig_en} sample is captured only after
//   it has held for STABLE_CYCLES cycles. Once all four digits have been
//   captured, the assembled frame is presented on a valid/ready output.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   seg_in     : segment levels, active-high, [6]=a .. [0]=g
//   dig_en     : one-hot digit select; bit i selects digit i
//   out_ready  : consumer accepts the presented frame
//   value      : decoded frame; digit i occupies value[4i+3:4i]
//   digit_err  : bit i set when digit i held an undecodable pattern
//   out_valid  : value/digit_err hold a frame that has not been accepted
//   overrun    : one-cycle pulse when a completed frame is dropped
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_en,
  input  logic        out_ready,
  output logic [15:0] value,
  output logic [3:0]  digit_err,
  output logic        out_valid,
  output logic        overrun
);

  localparam int          NUM_DIG = 4;
  localparam logic [7:0]  C_MAX   = 8'(STABLE_CYCLES - 1);

  // Returns {err, nibble}. Unknown patterns decode to nibble 0 with err set.
  function automatic logic [4:0] dec7(input logic [6:0] s);
    case (s)
      7'b1111110: dec7 = 5'h00;
      7'b0110000: dec7 = 5'h01;
      7'b1101101: dec7 = 5'h02;
      7'b1111001: dec7 = 5'h03;
      7'b0110011: dec7 = 5'h04;
      7'b1011011: dec7 = 5'h05;
      7'b1011111: dec7 = 5'h06;
      7'b1110000: dec7 = 5'h07;
      7'b1111111: dec7 = 5'h08;
      7'b1111011: dec7 = 5'h09;
      7'b1110111: dec7 = 5'h0A;
      7'b0011111: dec7 = 5'h0B;
      7'b1001110: dec7 = 5'h0C;
      7'b0111101: dec7 = 5'h0D;
      7'b1001111: dec7 = 5'h0E;
      7'b1000111: dec7 = 5'h0F;
      default:    dec7 = 5'h10;
    endcase
  endfunction

  // Two-deep sample history: r_seg/r_en is the sample under test and
  // r_pseg/r_pen is the one before it. Comparing registered samples,
  // rather than the live input, gives the STABLE_CYCLES+1 latency.
  logic [6:0]                    r_seg, r_pseg;
  logic [NUM_DIG-1:0]            r_en, r_pen;
  logic [7:0]                    r_cnt;
  logic [NUM_DIG-1:0]            r_mask;
  logic [NUM_DIG-1:0][3:0]       r_pnib;
  logic [NUM_DIG-1:0]            r_perr;
  logic [15:0]                   r_value;
  logic [NUM_DIG-1:0]            r_derr;
  logic                          r_vld;
  logic                          r_ovr;

  logic                          w_same;
  logic                          w_onehot;
  logic [7:0]                    w_cnt_nxt;
  logic                          w_cap;
  logic [4:0]                    w_dec;
  logic [NUM_DIG-1:0]            w_mask_nxt;
  logic                          w_done;
  logic [NUM_DIG-1:0][3:0]       w_nnib;
  logic [NUM_DIG-1:0]            w_nerr;

  assign w_same   = ({r_seg, r_en} == {r_pseg, r_pen});
  assign w_onehot = (r_en != '0) && ((r_en & (r_en - 4'd1)) == '0);
  assign w_dec    = dec7(r_seg);

  // Counter is pinned to 0 whenever the select is not one-hot, so a
  // capture can only ever target exactly one digit.
  always_comb begin
    w_cnt_nxt = '0;
    if (w_onehot && w_same)
      w_cnt_nxt = (r_cnt == C_MAX) ? C_MAX : r_cnt + 8'd1;
  end

  // Fires only on the edge into saturation: one capture per stable period.
  assign w_cap      = (w_cnt_nxt == C_MAX) && (r_cnt != C_MAX);
  assign w_mask_nxt = r_mask | (w_cap ? r_en : '0);
  assign w_done     = (w_mask_nxt == 4'hF);

  // Per-digit pending slot; a recapture simply overwrites the slot.
  for (genvar i = 0; i < NUM_DIG; i++) begin : g_slot
    assign w_nnib[i] = (w_cap && r_en[i]) ? w_dec[3:0] : r_pnib[i];
    assign w_nerr[i] = (w_cap && r_en[i]) ? w_dec[4]   : r_perr[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg   <= '0;
      r_en    <= '0;
      r_pseg  <= '0;
      r_pen   <= '0;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_pnib  <= '0;
      r_perr  <= '0;
      r_value <= '0;
      r_derr  <= '0;
      r_vld   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_seg   <= seg_in;
      r_en    <= dig_en;
      r_pseg  <= r_seg;
      r_pen   <= r_en;
      r_cnt   <= w_cnt_nxt;
      r_mask  <= w_done ? '0 : w_mask_nxt;
      r_pnib  <= w_nnib;
      r_perr  <= w_nerr;
      r_ovr   <= 1'b0;
      if (w_done) begin
        if (!r_vld || out_ready) begin
          r_value <= w_nnib;
          r_derr  <= w_nerr;
          r_vld   <= 1'b1;
        end else begin
          // Consumer still holds the previous frame: drop the new one.
          r_ovr <= 1'b1;
        end
      end else if (r_vld && out_ready) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign value     = r_value;
  assign digit_err = r_derr;
  assign out_valid = r_vld;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: drives digit scans as linear
// steps and compares outputs against hand-computed frames.
module tb_seg7_scan_decoder;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                         S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                         S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111,
                         S9 = 7'b1111011, SA = 7'b1110111, SB = 7'b0011111,
                         SC = 7'b1001110, SD = 7'b0111101, SE = 7'b1001111,
                         SF = 7'b1000111, SBAD = 7'b1010101, SBLK = 7'b0000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_en = '0;
  logic        out_ready = 1'b1;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        out_valid;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .dig_en    (dig_en),
    .out_ready (out_ready),
    .value     (value),
    .digit_err (digit_err),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic dig(input logic [6:0] s, input int idx, input int n);
    seg_in = s;
    dig_en = 4'(1 << idx);
    repeat (n) tick();
  endtask

  task automatic idle();
    seg_in = '0;
    dig_en = '0;
    tick();
  endtask

  task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    dig(s0, 0, 4);
    dig(s1, 1, 4);
    dig(s2, 2, 4);
    dig(s3, 3, 4);
    idle();
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_value", value, 16'h0000);
    chk("rst_err", 16'(digit_err), 16'h0);
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_ovr", 16'(overrun), 16'h0);
    rst_n = 1'b1;
    tick();

    // Basic frame 4321 and latency
    dig(S1, 0, 4);
    dig(S2, 1, 4);
    dig(S3, 2, 4);
    dig(S4, 3, 4);
    chk("lat_early", 16'(out_valid), 16'h0);
    idle();
    chk("f4321_valid", 16'(out_valid), 16'h1);
    chk("f4321_value", value, 16'h4321);
    chk("f4321_err", 16'(digit_err), 16'h0);
    chk("f4321_ovr", 16'(overrun), 16'h0);
    idle();
    chk("f4321_clr", 16'(out_valid), 16'h0);
    chk("f4321_hold", value, 16'h4321);

    // Digit 0 short by one cycle -> no frame, then re-driven
    dig(S5, 0, 3);
    dig(S6, 1, 4);
    dig(S7, 2, 4);
    dig(S9, 3, 4);
    idle();
    chk("short_noframe", 16'(out_valid), 16'h0);
    dig(S5, 0, 4);
    idle();
    chk("short_valid", 16'(out_valid), 16'h1);
    chk("short_value", value, 16'h9765);
    idle();

    // Undecodable pattern on digit 2
    frame(S8, S8, SBAD, S8);
    chk("bad_value", value, 16'h8088);
    chk("bad_err", 16'(digit_err), 16'h4);
    idle();

    // Out-of-order scan, letters A..D
    dig(SD, 3, 4);
    dig(SB, 1, 4);
    dig(SA, 0, 4);
    dig(SC, 2, 4);
    idle();
    chk("abcd_value", value, 16'hDCBA);
    chk("abcd_err", 16'(digit_err), 16'h0);
    idle();

    // E, F, 0, blank
    frame(SE, SF, S0, SBLK);
    chk("ef0_value", value, 16'h00FE);
    chk("ef0_err", 16'(digit_err), 16'h8);
    idle();

    // Multi-bit select must not capture
    seg_in = S8;
    dig_en = 4'b0011;
    repeat (10) tick();
    dig(S2, 2, 4);
    dig(S1, 3, 4);
    idle();
    chk("multi_noframe", 16'(out_valid), 16'h0);
    dig(S4, 0, 4);
    dig(S7, 1, 4);
    idle();
    chk("multi_valid", 16'(out_valid), 16'h1);
    chk("multi_value", value, 16'h1274);
    chk("multi_err", 16'(digit_err), 16'h0);
    idle();

    // Overrun with consumer stalled
    out_ready = 1'b0;
    frame(S1, S1, S1, S1);
    chk("ovr_f1_valid", 16'(out_valid), 16'h1);
    chk("ovr_f1_value", value, 16'h1111);
    chk("ovr_f1_ovr", 16'(overrun), 16'h0);
    idle();
    frame(S2, S2, S2, S2);
    chk("ovr_pulse", 16'(overrun), 16'h1);
    chk("ovr_value", value, 16'h1111);
    chk("ovr_valid", 16'(out_valid), 16'h1);
    idle();
    chk("ovr_one_cycle", 16'(overrun), 16'h0);
    chk("ovr_valid_hold", 16'(out_valid), 16'h1);
    out_ready = 1'b1;
    idle();
    chk("ovr_accept", 16'(out_valid), 16'h0);
    chk("ovr_accept_hold", value, 16'h1111);

    // Reset mid-frame discards partial captures
    dig(S3, 0, 4);
    dig(S3, 1, 4);
    dig(S3, 2, 4);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_value", value, 16'h0000);
    chk("arst_valid", 16'(out_valid), 16'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    dig(S6, 3, 4);
    idle();
    chk("post_rst_noframe", 16'(out_valid), 16'h0);
    chk("post_rst_value", value, 16'h0000);
    dig(S3, 0, 4);
    dig(S3, 1, 4);
    dig(S3, 2, 4);
    idle();
    chk("post_rst_valid", 16'(out_valid), 16'h1);
    chk("post_rst_frame", value, 16'h6333);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
